// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix-multiply sequencer and the MAC block it feeds.
package mm_pkg;

    localparam int DIM_W_DEF  = 16;
    localparam int ADDR_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } seq_state_t;

    // One MAC operation as seen by the downstream MAC pipeline
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] a_addr;
        logic [ADDR_W_DEF-1:0] b_addr;
        logic [ADDR_W_DEF-1:0] c_addr;
        logic                  acc_first;
        logic                  acc_last;
    } mac_op_t;

    // A dimension is usable when it is nonzero and fits in dim_w bits
    function automatic logic dim_legal(input logic [31:0] cfg, input int dim_w);
        return (cfg != 32'd0) && ((cfg >> dim_w) == 32'd0);
    endfunction

endpackage

// File: rtl/mm_loop_sequencer_if.sv
// MAC operation channel: valid/ready handshake carrying operand addresses and accumulate flags.
interface mm_loop_sequencer_if
    import mm_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              op_valid;
    logic              op_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [ADDR_W-1:0] c_addr;
    logic              acc_first;
    logic              acc_last;

    modport master (
        output op_valid, a_addr, b_addr, c_addr, acc_first, acc_last,
        input  op_ready
    );

    modport slave (
        input  op_valid, a_addr, b_addr, c_addr, acc_first, acc_last,
        output op_ready
    );

endinterface

// File: rtl/mm_nested_counter.sv
// i/j/k loop counters for the matmul nest: k innermost, then j, then i, stepped once per handshake.
module mm_nested_counter #(
    parameter int DIM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             step,
    input  logic [DIM_W-1:0] dim_m,
    input  logic [DIM_W-1:0] dim_n,
    input  logic [DIM_W-1:0] dim_k,
    output logic [DIM_W-1:0] j_count,
    output logic             k_first,
    output logic             k_last,
    output logic             j_last,
    output logic             i_last
);

    logic [DIM_W-1:0] i_count;
    logic [DIM_W-1:0] k_count;

    assign k_first = (k_count == '0);
    assign k_last  = (k_count == dim_k - DIM_W'(1));
    assign j_last  = (j_count == dim_n - DIM_W'(1));
    assign i_last  = (i_count == dim_m - DIM_W'(1));

    // Ripple the wrap of each inner counter into the next outer one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_count <= '0;
            j_count <= '0;
            k_count <= '0;
        end else if (clear) begin
            i_count <= '0;
            j_count <= '0;
            k_count <= '0;
        end else if (step) begin
            if (k_last) begin
                k_count <= '0;
                if (j_last) begin
                    j_count <= '0;
                    i_count <= i_last ? '0 : i_count + DIM_W'(1);
                end else begin
                    j_count <= j_count + DIM_W'(1);
                end
            end else begin
                k_count <= k_count + DIM_W'(1);
            end
        end
    end

endmodule

// File: rtl/mm_loop_sequencer.sv
// Walks the i/j/k nest of C = A*B, issuing one MAC op per handshake, then drains and pulses done.
module mm_loop_sequencer
    import mm_pkg::*;
#(
    parameter int DIM_W   = DIM_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int MAC_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] cfg_m,
    input  logic [31:0] cfg_k,
    input  logic [31:0] cfg_n,
    mm_loop_sequencer_if.master op,
    output logic        busy,
    output logic        done,
    output logic        cfg_err
);

    localparam int DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = (MAC_LAT > 0) ? DRAIN_W'(MAC_LAT - 1) : '0;

    seq_state_t        state;
    seq_state_t        state_next;
    logic [DIM_W-1:0]  dim_m;
    logic [DIM_W-1:0]  dim_k;
    logic [DIM_W-1:0]  dim_n;
    logic [ADDR_W-1:0] a_addr_q;
    logic [ADDR_W-1:0] b_addr_q;
    logic [ADDR_W-1:0] c_addr_q;
    logic [ADDR_W-1:0] a_row_base;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [DIM_W-1:0]  j_count;
    logic              k_first;
    logic              k_last;
    logic              j_last;
    logic              i_last;
    logic              accept;
    logic              cfg_bad;
    logic              handshake;
    logic              final_op;

    assign accept    = (state == IDLE) && start;
    assign cfg_bad   = !(dim_legal(cfg_m, DIM_W) && dim_legal(cfg_k, DIM_W) && dim_legal(cfg_n, DIM_W));
    assign handshake = (state == RUN) && op.op_ready;
    assign final_op  = handshake && k_last && j_last && i_last;

    assign op.a_addr = a_addr_q;
    assign op.b_addr = b_addr_q;
    assign op.c_addr = c_addr_q;

    mm_nested_counter #(
        .DIM_W (DIM_W)
    ) u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .step    (handshake),
        .dim_m   (dim_m),
        .dim_n   (dim_n),
        .dim_k   (dim_k),
        .j_count (j_count),
        .k_first (k_first),
        .k_last  (k_last),
        .j_last  (j_last),
        .i_last  (i_last)
    );

    // State register; reset abandons any job in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and op/status outputs; flags are only driven while an op is offered
    always_comb begin
        state_next   = state;
        op.op_valid  = 1'b0;
        op.acc_first = 1'b0;
        op.acc_last  = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = cfg_bad ? DONE : RUN;
                end
            end
            RUN: begin
                op.op_valid  = 1'b1;
                op.acc_first = k_first;
                op.acc_last  = k_last;
                if (final_op) begin
                    state_next = (MAC_LAT == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the job dimensions and the sticky config-error flag when a start is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dim_m   <= '0;
            dim_k   <= '0;
            dim_n   <= '0;
            cfg_err <= 1'b0;
        end else if (accept) begin
            dim_m   <= cfg_m[DIM_W-1:0];
            dim_k   <= cfg_k[DIM_W-1:0];
            dim_n   <= cfg_n[DIM_W-1:0];
            cfg_err <= cfg_bad;
        end
    end

    // Count out the MAC pipeline latency after the last op before reporting done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= '0;
        end else if (final_op) begin
            drain_cnt <= DRAIN_LOAD;
        end else if ((state == DRAIN) && (drain_cnt != '0)) begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
        end
    end

    // Add-only address walk: a steps by 1 along k and by K per row, b by N along k, c by 1 per output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_addr_q   <= '0;
            b_addr_q   <= '0;
            c_addr_q   <= '0;
            a_row_base <= '0;
        end else if (accept) begin
            a_addr_q   <= '0;
            b_addr_q   <= '0;
            c_addr_q   <= '0;
            a_row_base <= '0;
        end else if (handshake) begin
            if (k_last) begin
                c_addr_q <= c_addr_q + ADDR_W'(1);
                if (j_last) begin
                    a_row_base <= a_row_base + ADDR_W'(dim_k);
                    a_addr_q   <= a_row_base + ADDR_W'(dim_k);
                    b_addr_q   <= '0;
                end else begin
                    a_addr_q <= a_row_base;
                    b_addr_q <= ADDR_W'(j_count) + ADDR_W'(1);
                end
            end else begin
                a_addr_q <= a_addr_q + ADDR_W'(1);
                b_addr_q <= b_addr_q + ADDR_W'(dim_n);
            end
        end
    end

endmodule

// File: tb/tb_mm_loop_sequencer.sv
// Bench for mm_loop_sequencer: two builds (MAC_LAT=2 and MAC_LAT=0) share one stimulus stream
// and are compared every cycle against an op-list model built from the matmul loop nest.
module tb_mm_loop_sequencer;
    import mm_pkg::*;

    localparam int LAT_A = 2;
    localparam int LAT_Z = 0;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] cfg_m;
    logic [31:0] cfg_k;
    logic [31:0] cfg_n;
    logic        ready;
    logic        busy_a, done_a, err_a;
    logic        busy_z, done_z, err_z;

    int          ready_pct;
    int          checks;
    int          errors;
    int          cyc;
    int          done_at [2];
    bit          m_err;
    mac_op_t     exp_q [$];

    int          job_hs;
    int          pin_idx;
    bit          pin_hit;
    mac_op_t     pin_op;
    int          last_hs_cyc;
    int          done_cnt [2];
    int          done_cyc [2];

    mm_loop_sequencer_if #(.ADDR_W(16)) op_a ();
    mm_loop_sequencer_if #(.ADDR_W(16)) op_z ();

    assign op_a.op_ready = ready;
    assign op_z.op_ready = ready;

    mm_loop_sequencer #(.DIM_W(16), .ADDR_W(16), .MAC_LAT(LAT_A)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .cfg_m   (cfg_m),
        .cfg_k   (cfg_k),
        .cfg_n   (cfg_n),
        .op      (op_a),
        .busy    (busy_a),
        .done    (done_a),
        .cfg_err (err_a)
    );

    mm_loop_sequencer #(.DIM_W(16), .ADDR_W(16), .MAC_LAT(LAT_Z)) dut_z (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .cfg_m   (cfg_m),
        .cfg_k   (cfg_k),
        .cfg_n   (cfg_n),
        .op      (op_z),
        .busy    (busy_z),
        .done    (done_z),
        .cfg_err (err_z)
    );

    initial begin
        clk = 1'b0;
        done_at[0] = -1;
        done_at[1] = -1;
    end

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h cycle=%0d", name, actual, expected, cyc);
        end
    endtask

    function automatic bit model_idle();
        return (exp_q.size() == 0) && (cyc > done_at[0]) && (cyc > done_at[1]);
    endfunction

    // Randomised back-pressure on the op channel
    always @(posedge clk) begin
        #1;
        ready = ($urandom_range(99, 0) < ready_pct);
    end

    // Reference model: a start taken while idle expands the whole loop nest into an op list;
    // each accepted handshake consumes one op, and done follows the last one after the MAC latency
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            done_at[0] = -1;
            done_at[1] = -1;
            m_err = 1'b0;
        end else if (exp_q.size() != 0) begin
            if (ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    done_at[0] = cyc + 1 + LAT_A;
                    done_at[1] = cyc + 1 + LAT_Z;
                end
            end
        end else if (start && (cyc > done_at[0]) && (cyc > done_at[1])) begin
            m_err = !((cfg_m >= 1) && (cfg_m <= 32'hFFFF) && (cfg_k >= 1) && (cfg_k <= 32'hFFFF) &&
                      (cfg_n >= 1) && (cfg_n <= 32'hFFFF));
            if (m_err) begin
                done_at[0] = cyc + 1;
                done_at[1] = cyc + 1;
            end else begin
                for (int i = 0; i < int'(cfg_m); i++) begin
                    for (int j = 0; j < int'(cfg_n); j++) begin
                        for (int k = 0; k < int'(cfg_k); k++) begin
                            mac_op_t o;
                            o.a_addr    = 16'(i * int'(cfg_k) + k);
                            o.b_addr    = 16'(k * int'(cfg_n) + j);
                            o.c_addr    = 16'(i * int'(cfg_n) + j);
                            o.acc_first = (k == 0);
                            o.acc_last  = (k == int'(cfg_k) - 1);
                            exp_q.push_back(o);
                        end
                    end
                end
            end
        end
        cyc++;
    end

    // Per-cycle comparison of both builds against the model, plus bookkeeping for literal checks
    always @(negedge clk) begin
        logic        v, f, l, bz, dn, er;
        logic [15:0] a, b, c;
        bit          exp_valid;
        exp_valid = (exp_q.size() != 0);
        for (int d = 0; d < 2; d++) begin
            v  = (d == 0) ? op_a.op_valid  : op_z.op_valid;
            f  = (d == 0) ? op_a.acc_first : op_z.acc_first;
            l  = (d == 0) ? op_a.acc_last  : op_z.acc_last;
            a  = (d == 0) ? op_a.a_addr    : op_z.a_addr;
            b  = (d == 0) ? op_a.b_addr    : op_z.b_addr;
            c  = (d == 0) ? op_a.c_addr    : op_z.c_addr;
            bz = (d == 0) ? busy_a         : busy_z;
            dn = (d == 0) ? done_a         : done_z;
            er = (d == 0) ? err_a          : err_z;
            checkOutput($sformatf("op_valid[%0d]", d), v, exp_valid);
            if (exp_valid) begin
                checkOutput($sformatf("a_addr[%0d]", d), a, exp_q[0].a_addr);
                checkOutput($sformatf("b_addr[%0d]", d), b, exp_q[0].b_addr);
                checkOutput($sformatf("c_addr[%0d]", d), c, exp_q[0].c_addr);
                checkOutput($sformatf("acc_first[%0d]", d), f, exp_q[0].acc_first);
                checkOutput($sformatf("acc_last[%0d]", d), l, exp_q[0].acc_last);
            end else begin
                checkOutput($sformatf("acc_first_idle[%0d]", d), f, 1'b0);
                checkOutput($sformatf("acc_last_idle[%0d]", d), l, 1'b0);
            end
            if (!rst_n) begin
                checkOutput($sformatf("reset_addr[%0d]", d), {a, b}, 32'd0);
                checkOutput($sformatf("reset_c[%0d]", d), c, 16'd0);
            end
            checkOutput($sformatf("done[%0d]", d), dn, cyc == done_at[d]);
            checkOutput($sformatf("busy[%0d]", d), bz, exp_valid || (cyc <= done_at[d]));
            checkOutput($sformatf("cfg_err[%0d]", d), er, m_err);
            if (dn) begin
                done_cnt[d]++;
                done_cyc[d] = cyc;
            end
        end
        if (op_a.op_valid && ready) begin
            if (job_hs == pin_idx) begin
                pin_hit = 1'b1;
                pin_op  = {op_a.a_addr, op_a.b_addr, op_a.c_addr, op_a.acc_first, op_a.acc_last};
            end
            job_hs++;
            last_hs_cyc = cyc;
        end
    end

    task automatic clearJobStats(input int pin);
        job_hs      = 0;
        pin_idx     = pin;
        pin_hit     = 1'b0;
        pin_op      = '0;
        last_hs_cyc = -100;
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        done_cyc[0] = -1;
        done_cyc[1] = -1;
    endtask

    task automatic pulseStart(input logic [31:0] m, input logic [31:0] k, input logic [31:0] n);
        @(posedge clk);
        #2;
        cfg_m = m;
        cfg_k = k;
        cfg_n = n;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    // Run one job to completion; poke>0 re-pulses start with a changed cfg_m while the job runs
    task automatic applyStimulus(input logic [31:0] m, input logic [31:0] k, input logic [31:0] n,
                                 input int pct, input int poke, input int pin);
        bit finished;
        clearJobStats(pin);
        ready_pct = pct;
        finished  = 1'b0;
        pulseStart(m, k, n);
        for (int t = 0; t < 4000; t++) begin
            if (poke > 0 && t == poke) begin
                cfg_m = 32'd5;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #2;
            if (model_idle()) begin
                finished = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!finished) checkOutput("job_timeout", 32'd0, 32'd1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        int m, k, n, hs_exp;
        bit reached;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        m_err     = 1'b0;
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_m     = '0;
        cfg_k     = '0;
        cfg_n     = '0;
        ready     = 1'b0;
        ready_pct = 100;
        clearJobStats(0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_busy", busy_a, 1'b0);
        checkOutput("reset_op_valid", op_a.op_valid, 1'b0);
        checkOutput("reset_done", done_a, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] 2x3x2 job, op_ready held high");
        applyStimulus(2, 3, 2, 100, 0, 8);
        checkOutput("ops_2x3x2", job_hs, 12);
        checkOutput("pin_seen", pin_hit, 1'b1);
        checkOutput("pin_a_addr", pin_op.a_addr, 16'd5);
        checkOutput("pin_b_addr", pin_op.b_addr, 16'd4);
        checkOutput("pin_c_addr", pin_op.c_addr, 16'd2);
        checkOutput("pin_acc_last", pin_op.acc_last, 1'b1);
        checkOutput("pin_acc_first", pin_op.acc_first, 1'b0);
        checkOutput("done_count_lat2", done_cnt[0], 1);
        checkOutput("done_gap_lat2", done_cyc[0] - last_hs_cyc, LAT_A + 1);
        checkOutput("done_gap_lat0", done_cyc[1] - last_hs_cyc, LAT_Z + 1);
        checkOutput("busy_after_job", busy_a, 1'b0);

        $display("[TB] 2x3x2 job with 30%% stalls");
        applyStimulus(2, 3, 2, 70, 0, 8);
        checkOutput("ops_stall", job_hs, 12);
        checkOutput("pin_stall_a", pin_op.a_addr, 16'd5);
        checkOutput("done_count_stall", done_cnt[0], 1);

        $display("[TB] illegal configurations");
        applyStimulus(2, 0, 2, 100, 0, 0);
        checkOutput("ops_k0", job_hs, 0);
        checkOutput("cfg_err_k0", err_a, 1'b1);
        checkOutput("done_count_k0", done_cnt[0], 1);
        applyStimulus(2, 2, 32'h0001_0000, 100, 0, 0);
        checkOutput("ops_nwide", job_hs, 0);
        checkOutput("cfg_err_nwide", err_z, 1'b1);
        applyStimulus(1, 2, 2, 100, 0, 0);
        checkOutput("cfg_err_cleared", err_a, 1'b0);
        checkOutput("ops_1x2x2", job_hs, 4);

        $display("[TB] start and cfg_m disturbed mid-run");
        applyStimulus(2, 3, 2, 100, 3, 8);
        checkOutput("ops_poke", job_hs, 12);
        checkOutput("pin_poke_c", pin_op.c_addr, 16'd2);
        checkOutput("done_count_poke_a", done_cnt[0], 1);
        checkOutput("done_count_poke_z", done_cnt[1], 1);

        $display("[TB] reset during op 5");
        clearJobStats(0);
        ready_pct = 100;
        reached   = 1'b0;
        pulseStart(2, 3, 2);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            #2;
            if (job_hs >= 5) begin
                reached = 1'b1;
                break;
            end
        end
        if (!reached) checkOutput("reach_op5", 32'd0, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_op_valid", op_a.op_valid, 1'b0);
        checkOutput("async_busy", busy_a, 1'b0);
        checkOutput("async_a_addr", op_a.a_addr, 16'd0);
        checkOutput("async_c_addr", op_a.c_addr, 16'd0);
        checkOutput("async_acc_first", op_a.acc_first, 1'b0);
        checkOutput("async_busy_z", busy_z, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        checkOutput("no_done_after_reset", done_cnt[0] + done_cnt[1], 0);

        applyStimulus(1, 1, 1, 100, 0, 0);
        checkOutput("ops_1x1x1", job_hs, 1);
        checkOutput("one_first", pin_op.acc_first, 1'b1);
        checkOutput("one_last", pin_op.acc_last, 1'b1);
        checkOutput("one_addr", {pin_op.a_addr, pin_op.b_addr}, 32'd0);
        checkOutput("one_c_addr", pin_op.c_addr, 16'd0);

        $display("[TB] 1x1x4 job, zero-latency build");
        applyStimulus(1, 4, 1, 100, 0, 3);
        checkOutput("ops_1x4x1", job_hs, 4);
        checkOutput("done_gap_lat0_k4", done_cyc[1] - last_hs_cyc, 1);
        checkOutput("k4_last_a", pin_op.a_addr, 16'd3);
        checkOutput("k4_last_b", pin_op.b_addr, 16'd3);
        checkOutput("k4_last_flag", pin_op.acc_last, 1'b1);

        $display("[TB] randomised jobs");
        for (int r = 0; r < 10; r++) begin
            m = $urandom_range(4, 1);
            k = ($urandom_range(9, 0) == 0) ? 0 : $urandom_range(4, 1);
            n = $urandom_range(4, 1);
            hs_exp = m * k * n;
            applyStimulus(m, k, n, $urandom_range(100, 40),
                          (hs_exp >= 4 && $urandom_range(1, 0) == 1) ? 2 : 0, 0);
            checkOutput($sformatf("rand_ops[%0d]", r), job_hs, hs_exp);
            checkOutput($sformatf("rand_done[%0d]", r), done_cnt[0] + done_cnt[1], 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
